stack_sequencer: RTL and testbench

- Executes the push/pop register bitmasks carried in nec_decode_t.push / nec_decode_t.pop; it is the consumer of the STACK_* bit encoding.
- Walks the set bits in mask order, issues one 16-bit SS-relative memory access per bit and moves data between the register file and the stack.
- Sits between the execute stage, the register file and the bus interface unit.
- Used for PUSH/POP, PUSH R/POP R, interrupt entry (PSW, PS, PC) and RETI.

---
 rtl/stack_sequencer.sv | 158 +++++++++++++++
 tb/tb_stack_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
//
// Walks a STACK_* register bitmask and moves one 16-bit word per set bit
// between the register file and the SS-relative stack. Used for PUSH/POP,
// PUSH R/POP R, interrupt entry (PSW, PS, PC) and RETI.
//
// Slot order: push services the lowest set bit first, pop the highest first.
// Bit 4 (STACK_SP) pushes the SP value captured at start, and on pop it
// reloads SP from memory. Bit 5 (STACK_BP_SKIP_SP) pushes like bit 4, and on
// pop it does the read but discards the data.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                one-cycle request, honoured only while idle
//   is_pop, mask, sp_in  operation descriptor, latched with start
//   reg_sel              bit index of the slot in service (register-file port)
//   reg_rdata            register value for reg_sel (same-cycle)
//   reg_we, reg_wdata    register write-back on pop
//   mem_req/wr/addr/wdata/ack/rdata  bus-interface handshake
//   sp_out, sp_we        working SP, write strobe pulsed with done
//   busy, done           status
// ---------------------------------------------------------------------------
module stack_sequencer #(
    parameter int ADDR_STEP = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_pop,
    input  logic [15:0] mask,
    input  logic [15:0] sp_in,
    output logic [3:0]  reg_sel,
    input  logic [15:0] reg_rdata,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] sp_out,
    output logic        sp_we,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] STEP = 16'(ADDR_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] mask_reg;
    logic [15:0] sp_reg;
    logic [15:0] orig_sp_reg;
    logic        is_pop_reg;

    logic [3:0]  slot_sel;
    logic [15:0] mask_next;
    logic        in_bus;
    logic        slot_is_sp;
    logic        slot_is_skip;

    // Priority encoder over the bits still pending. The loop direction picks
    // which end wins: for a push the last match scanning downwards is the
    // lowest bit; for a pop the last match scanning upwards is the highest.
    always_comb begin
        slot_sel = 4'd0;
        if (is_pop_reg) begin
            for (int i = 0; i < 16; i++) begin
                if (mask_reg[i]) begin
                    slot_sel = 4'(i);
                end
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (mask_reg[i]) begin
                    slot_sel = 4'(i);
                end
            end
        end
    end

    assign mask_next    = mask_reg & ~(16'h0001 << slot_sel);
    assign in_bus       = (state_reg == BUS);
    assign slot_is_sp   = (slot_sel == 4'd4);
    assign slot_is_skip = (slot_sel == 4'd5);

    // Bus-side outputs are derived from registered state only (plus the
    // same-cycle register read), so they hold steady while waiting for ack.
    assign mem_req   = in_bus;
    assign mem_wr    = in_bus & ~is_pop_reg;
    assign mem_addr  = !in_bus    ? 16'h0000 :
                       is_pop_reg ? sp_reg   : (sp_reg - STEP);
    assign mem_wdata = (!in_bus || is_pop_reg)     ? 16'h0000    :
                       (slot_is_sp || slot_is_skip) ? orig_sp_reg : reg_rdata;
    assign reg_sel   = in_bus ? slot_sel : 4'd0;

    // Write-back happens in the ack cycle because read data is only valid
    // then. A reset in the same cycle suppresses it so an aborted pop never
    // touches the register file.
    assign reg_we    = in_bus & is_pop_reg & mem_ack & ~slot_is_sp & ~slot_is_skip & ~reset;
    assign reg_wdata = reg_we ? mem_rdata : 16'h0000;

    assign sp_out = sp_reg;
    assign sp_we  = (state_reg == DONE);
    assign done   = (state_reg == DONE);
    assign busy   = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            mask_reg    <= 16'h0000;
            sp_reg      <= 16'h0000;
            orig_sp_reg <= 16'h0000;
            is_pop_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mask_reg    <= mask;
                        is_pop_reg  <= is_pop;
                        sp_reg      <= sp_in;
                        orig_sp_reg <= sp_in;
                        state_reg   <= (mask != 16'h0000) ? BUS : DONE;
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        mask_reg <= mask_next;
                        if (!is_pop_reg) begin
                            sp_reg <= sp_reg - STEP;
                        end else if (slot_is_sp) begin
                            sp_reg <= mem_rdata;
                        end else begin
                            sp_reg <= sp_reg + STEP;
                        end
                        if (mask_next == 16'h0000) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_sequencer
//
// Directed bench for stack_sequencer. For each operation a list of expected
// bus transfers is built from the stacking rules; a per-cycle checker compares
// every presented request against the head of that list and retires it on
// ack. Literal values from hand calculation pin the results of each scenario.
// ---------------------------------------------------------------------------
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_pop;
    logic [15:0] mask;
    logic [15:0] sp_in;
    logic [3:0]  reg_sel;
    logic [15:0] reg_rdata;
    logic        reg_we;
    logic [15:0] reg_wdata;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] sp_out;
    logic        sp_we;
    logic        busy;
    logic        done;

    stack_sequencer #(.ADDR_STEP(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_pop    (is_pop),
        .mask      (mask),
        .sp_in     (sp_in),
        .reg_sel   (reg_sel),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .sp_out    (sp_out),
        .sp_we     (sp_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        logic [3:0]  sel;
        logic        we;
        logic [15:0] rdata;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    txn_t        exp_q[$];
    logic [15:0] exp_final;
    int          exp_done_cyc;
    bit          done_pending = 0;
    bit          done_seen = 0;
    bit          exp_busy = 0;
    bit          chk_en = 0;
    int          ack_delay = 0;
    bit          ack_hold = 0;
    int          wait_cnt = 0;
    int          reg_we_cnt = 0;
    int          txn_no = 0;
    logic [15:0] log_addr[$];
    logic [15:0] log_wdata[$];

    // Register file and memory contents as fixed functions of index/address.
    function automatic logic [15:0] rf_val(input logic [3:0] idx);
        return 16'hA0A0 ^ ({12'h000, idx} * 16'h1111);
    endfunction

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    assign reg_rdata = rf_val(reg_sel);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus responder: acks after ack_delay idle cycles on each request.
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (wait_cnt >= ack_delay && !ack_hold) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_val(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'hDEAD;
                wait_cnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            wait_cnt  = 0;
        end
    end

    // Per-cycle comparison against the expected transfer list.
    always @(negedge clk) begin
        txn_t t;
        #2;
        if (chk_en) begin
            chk("busy", {15'h0, busy}, {15'h0, exp_busy});
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request (cycle %0d)", mem_addr, cyc);
                end else begin
                    t = exp_q[0];
                    chk("mem_addr", mem_addr, t.addr);
                    chk("mem_wr", {15'h0, mem_wr}, {15'h0, t.wr});
                    chk("reg_sel", {12'h0, reg_sel}, {12'h0, t.sel});
                    if (t.wr) chk("mem_wdata", mem_wdata, t.wdata);
                    if (mem_ack) begin
                        chk("reg_we", {15'h0, reg_we}, {15'h0, t.we});
                        if (t.we) chk("reg_wdata", reg_wdata, t.rdata);
                        $display("txn %0d: cycle %0d %s slot %0d addr %h data %h reg_we %0b",
                                 txn_no, cyc, mem_wr ? "write" : "read ", reg_sel, mem_addr,
                                 mem_wr ? mem_wdata : mem_rdata, reg_we);
                        txn_no++;
                        log_addr.push_back(mem_addr);
                        log_wdata.push_back(mem_wr ? mem_wdata : mem_rdata);
                        exp_q.pop_front();
                    end
                end
            end
            if (reg_we) reg_we_cnt++;
            if (!mem_req || !mem_ack) chk("reg_we_quiet", {15'h0, reg_we}, 16'h0000);
            if (done) begin
                if (!done_pending) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("done_cycle", 16'(cyc), 16'(exp_done_cyc));
                    chk("sp_out", sp_out, exp_final);
                    chk("sp_we", {15'h0, sp_we}, 16'h0001);
                    chk("slots_left", 16'(exp_q.size()), 16'h0000);
                    $display("done: cycle %0d sp_out %h", cyc, sp_out);
                end
                done_pending = 0;
                done_seen    = 1;
                exp_busy     = 0;
            end else begin
                chk("sp_we_quiet", {15'h0, sp_we}, 16'h0000);
            end
        end
    end

    // Expected transfer list from the stacking rules.
    task automatic build_model(input logic p, input logic [15:0] m, input logic [15:0] sp,
                               output int n);
        txn_t        t;
        logic [15:0] spm;
        int          b;
        spm = sp;
        n = 0;
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            b = p ? 15 - k : k;
            if (m[b]) begin
                n++;
                t.sel = 4'(b);
                if (!p) begin
                    spm     = spm - 16'd2;
                    t.addr  = spm;
                    t.wr    = 1'b1;
                    t.wdata = (b == 4 || b == 5) ? sp : rf_val(4'(b));
                    t.we    = 1'b0;
                    t.rdata = 16'h0000;
                end else begin
                    t.addr  = spm;
                    t.wr    = 1'b0;
                    t.wdata = 16'h0000;
                    t.rdata = mem_val(spm);
                    t.we    = !(b == 4 || b == 5);
                    if (b == 4) spm = t.rdata;
                    else        spm = spm + 16'd2;
                end
                exp_q.push_back(t);
            end
        end
        exp_final = spm;
    endtask

    task automatic run_op(input logic p, input logic [15:0] m, input logic [15:0] sp,
                          input int d, input bit dup_start);
        int n;
        int s;
        int budget;
        build_model(p, m, sp, n);
        ack_delay  = d;
        reg_we_cnt = 0;
        log_addr.delete();
        log_wdata.delete();
        done_seen  = 0;
        @(posedge clk); #1;
        start  = 1'b1;
        is_pop = p;
        mask   = m;
        sp_in  = sp;
        s = cyc;
        exp_done_cyc = s + 1 + n * (d + 1);
        done_pending = 1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_busy = 1;
        mask     = 16'h0000;
        if (dup_start) begin
            @(posedge clk); #1;
            start  = 1'b1;
            is_pop = ~p;
            mask   = 16'hFFFF;
            sp_in  = 16'hBEEF;
            @(posedge clk); #1;
            start  = 1'b0;
            mask   = 16'h0000;
        end
        budget = 0;
        while (!done_seen && budget < 400) begin
            @(posedge clk);
            budget++;
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done by cycle %0d", exp_done_cyc);
            done_pending = 0;
            exp_busy     = 0;
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        is_pop = 1'b0;
        mask   = 16'h0000;
        sp_in  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        #3;
        chk("rst_mem_req", {15'h0, mem_req}, 16'h0000);
        chk("rst_busy", {15'h0, busy}, 16'h0000);
        chk("rst_done", {15'h0, done}, 16'h0000);
        chk("rst_sp_we", {15'h0, sp_we}, 16'h0000);
        chk("rst_sp_out", sp_out, 16'h0000);
        chk("rst_mem_wr", {15'h0, mem_wr}, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Interrupt entry: PSW, PS, PC
        run_op(1'b0, 16'h4C00, 16'h0100, 0, 0);
        chk("irq_addr0", log_addr[0], 16'h00FE);
        chk("irq_addr2", log_addr[2], 16'h00FA);
        chk("irq_sp", sp_out, 16'h00FA);

        // PUSH R
        run_op(1'b0, 16'h01DF, 16'h2000, 0, 0);
        chk("pushr_count", 16'(log_addr.size()), 16'd8);
        chk("pushr_sp_addr", log_addr[4], 16'h1FF6);
        chk("pushr_sp_data", log_wdata[4], 16'h2000);
        chk("pushr_sp", sp_out, 16'h1FF0);

        // POP R with the skip slot
        run_op(1'b1, 16'h01EF, 16'h1FF0, 0, 0);
        chk("popr_we_cnt", 16'(reg_we_cnt), 16'd7);
        chk("popr_first", log_addr[0], 16'h1FF0);
        chk("popr_skip_addr", log_addr[3], 16'h1FF6);
        chk("popr_last", log_addr[7], 16'h1FFE);
        chk("popr_sp", sp_out, 16'h2000);

        // Empty mask
        run_op(1'b0, 16'h0000, 16'h1234, 0, 0);
        chk("empty_reqs", 16'(log_addr.size()), 16'd0);
        chk("empty_sp", sp_out, 16'h1234);

        // Wrap below zero
        run_op(1'b0, 16'h0001, 16'h0000, 0, 0);
        chk("wrap_addr", log_addr[0], 16'hFFFE);
        chk("wrap_sp", sp_out, 16'hFFFE);

        // Wait states with an ignored second start
        run_op(1'b0, 16'h0013, 16'h4000, 3, 1);
        chk("wait_addr2", log_addr[2], 16'h3FFA);
        chk("wait_sp_data", log_wdata[2], 16'h4000);
        chk("wait_sp", sp_out, 16'h3FFA);

        // Pop through skip, then SP reload, then an ordinary register
        run_op(1'b1, 16'h0031, 16'h5000, 2, 0);
        chk("popsp_reload_addr", log_addr[2], 16'h0A58);
        chk("popsp_we_cnt", 16'(reg_we_cnt), 16'd1);
        chk("popsp_sp", sp_out, 16'h0A5A);

        // Reset while servicing slot 2 of 3
        build_model(1'b0, 16'h0007, 16'h3000, n);
        ack_delay = 0;
        log_addr.delete();
        log_wdata.delete();
        @(posedge clk); #1;
        start  = 1'b1;
        is_pop = 1'b0;
        mask   = 16'h0007;
        sp_in  = 16'h3000;
        exp_done_cyc = cyc + 1 + n;
        done_pending = 1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_busy = 1;
        @(posedge clk); #1;
        reset    = 1'b1;
        ack_hold = 1;
        #1;
        chk("rst_mid_sel", {12'h0, reg_sel}, 16'h0001);
        @(posedge clk); #1;
        reset    = 1'b0;
        ack_hold = 0;
        exp_q.delete();
        exp_busy     = 0;
        done_pending = 0;
        #2;
        chk("rst_mid_req", {15'h0, mem_req}, 16'h0000);
        chk("rst_mid_busy", {15'h0, busy}, 16'h0000);
        chk("rst_mid_done", {15'h0, done}, 16'h0000);
        chk("rst_mid_sp_we", {15'h0, sp_we}, 16'h0000);
        chk("rst_mid_sp", sp_out, 16'h0000);
        chk("rst_mid_txns", 16'(log_addr.size()), 16'd1);
        repeat (3) @(posedge clk);

        run_op(1'b0, 16'h0003, 16'h3000, 0, 0);
        chk("after_rst_addr1", log_addr[1], 16'h2FFC);
        chk("after_rst_sp", sp_out, 16'h2FFC);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
